// File: rtl/simd_bitserial_lane.sv
// Bit-serial SIMD lane: ADD/SUB/MUL/restoring-DIV advanced one micro-step per accepted start_bit.
// Latency: done_bit drops the edge after start_bit, rises one edge later; requests during EXEC are dropped.
module simd_bitserial_lane #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_op,
  input  logic                         start_bit,
  input  logic [$clog2(BIT_WIDTH)-1:0] bit_select,
  input  logic [1:0]                   op_code,
  input  logic [BIT_WIDTH-1:0]         a_input,
  input  logic [BIT_WIDTH-1:0]         b_input,
  output logic [BIT_WIDTH-1:0]         result_out,
  output logic                         done_bit,
  output logic                         div_by_zero
);
  localparam int SW = $clog2(BIT_WIDTH);
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t               state;
  logic [BIT_WIDTH-1:0] a_q, b_q, rem_q;
  logic [1:0]           op_q;
  logic [SW-1:0]        sel_q;
  logic                 carry_q;

  logic                 in_range, a_bit, b_bit, sum_bit, carry_nxt, div_ge;
  logic [SW-1:0]        div_idx;
  logic [BIT_WIDTH:0]   r_ext;
  logic [BIT_WIDTH-1:0] rem_nxt, mul_nxt;

  always_comb begin
    in_range  = ({1'b0, sel_q} < (SW+1)'(BIT_WIDTH));
    a_bit     = a_q[sel_q];
    b_bit     = b_q[sel_q] ^ (op_q == OP_SUB);
    sum_bit   = a_bit ^ b_bit ^ carry_q;
    carry_nxt = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
    mul_nxt   = result_out + (a_q << sel_q);
    // Division walks the dividend MSB-first while indices arrive ascending.
    div_idx   = SW'(BIT_WIDTH - 1) - sel_q;
    r_ext     = {rem_q, a_q[div_idx]};
    div_ge    = (r_ext >= {1'b0, b_q});
    rem_nxt   = div_ge ? (r_ext[BIT_WIDTH-1:0] - b_q) : r_ext[BIT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      op_q        <= OP_ADD;
      sel_q       <= '0;
      carry_q     <= 1'b0;
      result_out  <= '0;
      done_bit    <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (start_op) begin
      // Also aborts an in-flight step: the EXEC update below is skipped.
      state       <= IDLE;
      a_q         <= a_input;
      b_q         <= b_input;
      op_q        <= op_code;
      rem_q       <= '0;
      carry_q     <= (op_code == OP_SUB);
      result_out  <= '0;
      done_bit    <= 1'b0;
      div_by_zero <= (op_code == OP_DIV) && (b_input == '0);
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_bit) begin
            sel_q    <= bit_select;
            done_bit <= 1'b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (in_range) begin
            case (op_q)
              OP_ADD, OP_SUB: begin
                result_out[sel_q] <= sum_bit;
                carry_q           <= carry_nxt;
              end
              OP_MUL: begin
                if (b_q[sel_q]) result_out <= mul_nxt;
              end
              default: begin
                result_out[div_idx] <= div_ge;
                rem_q               <= rem_nxt;
              end
            endcase
          end
          done_bit <= 1'b1;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/simd_bitserial_lane.md
SIMD_BITSERIAL_LANE -- requirements
Module: simd_bitserial_lane

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, meaning per-lane operand/result width (>=2).
REQ-002 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_op  input  1  one-cycle pulse; latch operands/op_code, clear lane state.
REQ-005 SHALL have port start_bit  input  1  one-cycle request to execute one micro-step.
REQ-006 SHALL have port bit_select  input  $clog2(BIT_WIDTH)  micro-step index, sampled with start_bit.
REQ-007 SHALL have port op_code  input  2  0=ADD, 1=SUB, 2=MUL, 3=DIV (unsigned), sampled with start_op.
REQ-008 SHALL have port a_input  input  BIT_WIDTH  operand A, sampled with start_op.
REQ-009 SHALL have port b_input  input  BIT_WIDTH  operand B, sampled with start_op.
REQ-010 SHALL have port result_out  output  BIT_WIDTH  registered result register.
REQ-011 SHALL have port done_bit  output  1  registered level, high when last accepted micro-step complete.
REQ-012 SHALL have port div_by_zero  output  1  registered flag, DIV with B==0.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, DONE; EXEC lasts exactly one cycle.
REQ-014 On start_op: latch A, B, op_code; clear result, carry, remainder/accumulator; done_bit<=0; state<=IDLE; div_by_zero<=(op_code==3 && b_input==0).
REQ-015 start_op SHALL have priority; start_bit in same cycle as start_op SHALL be ignored (no step executed).
REQ-016 start_bit (without start_op) in IDLE or DONE SHALL be accepted: latch bit_select, done_bit<=0, state<=EXEC.
REQ-017 In EXEC: perform step for latched index i, then done_bit<=1, state<=DONE.
REQ-018 Latency: start_bit sampled at edge k -> done_bit low after edge k, high after edge k+1, held until next accepted start_bit or start_op.
REQ-019 start_bit while in EXEC SHALL be ignored.
REQ-020 start_op while in EXEC SHALL abort the step (no update) and apply REQ-014.
REQ-021 ADD step i: result[i]<=A[i]^B[i]^c; c<=majority(A[i],B[i],c); c cleared to 0 by start_op.
REQ-022 SUB step i: as ADD with ~B[i]; c initialised to 1 by start_op.
REQ-023 MUL step i: if B[i] then result<=(result + (A<<i)) mod 2^BIT_WIDTH; else unchanged.
REQ-024 DIV step i (restoring): j=BIT_WIDTH-1-i; r'={r,A[j]} (BIT_WIDTH+1 bits); if r'>=B then r<=r'-B, result[j]<=1 else r<=r', result[j]<=0; result = quotient.
REQ-025 DIV with B==0 SHALL yield quotient all ones after BIT_WIDTH steps; div_by_zero stays 1 until next start_op.
REQ-026 ADD/SUB/DIV correctness requires i issued ascending 0..BIT_WIDTH-1; MUL is order-independent; lane SHALL execute whatever index is presented.
REQ-027 Accepted start_bit with bit_select>=BIT_WIDTH SHALL update no datapath state but SHALL complete handshake per REQ-018.
REQ-028 result_out SHALL reflect partial results between steps; final value valid when done_bit high after step BIT_WIDTH-1.
REQ-029 Overflow/borrow SHALL be discarded; no carry-out port.

Reset
REQ-030 Reset SHALL force state IDLE, result_out=0, done_bit=0, div_by_zero=0, carry/remainder/latched operands=0, at any time including mid-EXEC.
REQ-031 After reset release, no step SHALL execute until a start_bit is sampled.

Verification (BIT_WIDTH=8; start_op then start_bit for i=0..7, each after done_bit)
REQ-032 ADD A=200 B=100 -> result_out=44, div_by_zero=0.
REQ-033 SUB A=5 B=7 -> result_out=254; SUB A=7 B=5 -> 2.
REQ-034 MUL A=13 B=11 -> 143; MUL A=20 B=20 -> 144.
REQ-035 DIV A=100 B=7 -> 14, div_by_zero=0; DIV A=9 B=0 -> 255, div_by_zero=1 from cycle after start_op.
REQ-036 start_op+start_bit same cycle then start_bit i=0 -> exactly one step; done_bit 0 one cycle after start_bit, 1 the next; start_bit during EXEC ignored.
REQ-037 DIV A=100 B=7, reset after step 3 -> all outputs 0 next cycle; new ADD 1+1 afterwards -> 2.
